// File: rtl/l1_cache_unit.sv
`default_nettype none
// ============================================================================
// Module   : l1_cache_unit
// Brief    : 2-way set-associative write-through, no-write-allocate L1 D-cache
//            (64 sets x 16-word lines, LRU replacement).
// Revision : 1.0 - initial release
// ============================================================================
module l1_cache_unit (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  phy_addr,
    input  logic [31:0]  data_from_cpu,
    input  logic         read_mem,
    input  logic         write_mem,
    output logic [31:0]  data_to_cpu,
    output logic         hit_miss,
    output logic         ready_stall,
    output logic [31:0]  main_mem_addr,
    output logic [31:0]  main_mem_data_out,
    output logic         main_mem_read_req,
    output logic         main_mem_write_req,
    input  logic [511:0] main_mem_data_in,
    input  logic         main_mem_ready
);

    localparam int unsigned c_NUM_SETS = 64;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_WAIT = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        hit_q, hit_d;
    logic        stall_q, stall_d;
    logic [63:0] valid0_q, valid1_q, lru_q;

    logic [19:0]  tag_q  [c_NUM_SETS][2];
    logic [511:0] line_q [c_NUM_SETS][2];

    // Lookup side works on the live CPU address
    logic [19:0]  w_tag;
    logic [5:0]   w_idx;
    logic [3:0]   w_word;
    logic         w_hit0, w_hit1, w_hit, w_hit_way;
    logic [511:0] w_hit_line;
    logic [31:0]  w_hit_word;

    assign w_tag      = phy_addr[31:12];
    assign w_idx      = phy_addr[11:6];
    assign w_word     = phy_addr[5:2];
    assign w_hit0     = valid0_q[w_idx] && (tag_q[w_idx][0] == w_tag);
    assign w_hit1     = valid1_q[w_idx] && (tag_q[w_idx][1] == w_tag);
    assign w_hit      = w_hit0 | w_hit1;
    assign w_hit_way  = w_hit1;
    assign w_hit_line = line_q[w_idx][w_hit_way];
    assign w_hit_word = w_hit_line[{w_word, 5'd0} +: 32];

    // Fill side works on the address latched at the miss
    logic [19:0] w_fill_tag;
    logic [5:0]  w_fill_idx;
    logic [3:0]  w_fill_word;
    logic        w_victim;
    logic [31:0] w_fill_data;

    assign w_fill_tag  = addr_q[31:12];
    assign w_fill_idx  = addr_q[11:6];
    assign w_fill_word = addr_q[5:2];
    assign w_victim    = !valid0_q[w_fill_idx] ? 1'b0 :
                         !valid1_q[w_fill_idx] ? 1'b1 : lru_q[w_fill_idx];
    assign w_fill_data = main_mem_data_in[{w_fill_word, 5'd0} +: 32];

    logic       w_fill_en, w_wr_hit_en, w_lru_en, w_lru_val;
    logic [5:0] w_lru_idx;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hit_d       = hit_q;
        stall_d     = stall_q;
        w_fill_en   = 1'b0;
        w_wr_hit_en = 1'b0;
        w_lru_en    = 1'b0;
        w_lru_val   = 1'b0;
        w_lru_idx   = w_idx;
        unique case (state_q)
            S_IDLE: begin
                if (write_mem) begin
                    addr_d      = phy_addr;
                    mem_addr_d  = phy_addr;
                    mem_wdata_d = data_from_cpu;
                    stall_d     = 1'b1;
                    hit_d       = w_hit;
                    w_wr_hit_en = w_hit;
                    w_lru_en    = w_hit;
                    w_lru_val   = ~w_hit_way;
                    state_d     = S_WR_REQ;
                end else if (read_mem) begin
                    if (w_hit) begin
                        rdata_d   = w_hit_word;
                        hit_d     = 1'b1;
                        w_lru_en  = 1'b1;
                        w_lru_val = ~w_hit_way;
                    end else begin
                        addr_d     = phy_addr;
                        mem_addr_d = {w_tag, w_idx, 6'd0};
                        hit_d      = 1'b0;
                        stall_d    = 1'b1;
                        state_d    = S_RD_REQ;
                    end
                end
            end
            S_RD_REQ:  state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (main_mem_ready) begin
                    w_fill_en = 1'b1;
                    rdata_d   = w_fill_data;
                    w_lru_en  = 1'b1;
                    w_lru_idx = w_fill_idx;
                    w_lru_val = ~w_victim;
                    stall_d   = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_WR_REQ:  state_d = S_WR_WAIT;
            S_WR_WAIT: begin
                if (main_mem_ready) begin
                    stall_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_q       <= 1'b0;
            stall_q     <= 1'b0;
            valid0_q    <= '0;
            valid1_q    <= '0;
            lru_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hit_q       <= hit_d;
            stall_q     <= stall_d;
            if (w_fill_en) begin
                if (w_victim) valid1_q[w_fill_idx] <= 1'b1;
                else          valid0_q[w_fill_idx] <= 1'b1;
            end
            if (w_lru_en) lru_q[w_lru_idx] <= w_lru_val;
        end
    end

    // Arrays carry no reset; enables derive from reset-cleared state
    always_ff @(posedge clk) begin
        if (w_fill_en) begin
            tag_q[w_fill_idx][w_victim]  <= w_fill_tag;
            line_q[w_fill_idx][w_victim] <= main_mem_data_in;
        end
        if (w_wr_hit_en) begin
            line_q[w_idx][w_hit_way][{w_word, 5'd0} +: 32] <= data_from_cpu;
        end
    end

    assign data_to_cpu        = rdata_q;
    assign hit_miss           = hit_q;
    assign ready_stall        = stall_q;
    assign main_mem_addr      = mem_addr_q;
    assign main_mem_data_out  = mem_wdata_q;
    assign main_mem_read_req  = (state_q == S_RD_REQ);
    assign main_mem_write_req = (state_q == S_WR_REQ);

    logic w_unused_bits;
    assign w_unused_bits = ^{phy_addr[1:0], addr_q[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_l1_cache_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_l1_cache_unit
// Brief    : Randomized self-checking bench for l1_cache_unit against a
//            recency-list cache model and a sparse main-memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l1_cache_unit;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  phy_addr;
    logic [31:0]  data_from_cpu;
    logic         read_mem;
    logic         write_mem;
    logic [31:0]  data_to_cpu;
    logic         hit_miss;
    logic         ready_stall;
    logic [31:0]  main_mem_addr;
    logic [31:0]  main_mem_data_out;
    logic         main_mem_read_req;
    logic         main_mem_write_req;
    logic [511:0] main_mem_data_in;
    logic         main_mem_ready;

    always #5 clk = ~clk;

    l1_cache_unit u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .phy_addr          (phy_addr),
        .data_from_cpu     (data_from_cpu),
        .read_mem          (read_mem),
        .write_mem         (write_mem),
        .data_to_cpu       (data_to_cpu),
        .hit_miss          (hit_miss),
        .ready_stall       (ready_stall),
        .main_mem_addr     (main_mem_addr),
        .main_mem_data_out (main_mem_data_out),
        .main_mem_read_req (main_mem_read_req),
        .main_mem_write_req(main_mem_write_req),
        .main_mem_data_in  (main_mem_data_in),
        .main_mem_ready    (main_mem_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    endtask

    // Main memory: explicit writes override a per-word hash pattern
    logic [31:0] mem_ovr [logic [29:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [29:0] k;
        k = a[31:2];
        if (mem_ovr.exists(k)) return mem_ovr[k];
        return ({k, 2'b00} * 32'h9E3779B1) ^ 32'h3C3C0F0F;
    endfunction

    function automatic logic [511:0] line_of(input logic [31:0] a);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[32*k +: 32] = mem_rd({a[31:6], 4'(k), 2'b00});
        return l;
    endfunction

    // Cache model: per set, the resident line tags ordered by recency
    logic [19:0] mru_t [64];
    logic [19:0] lru_t [64];
    int          cnt   [64];
    logic [31:0] exp_dout;

    function automatic bit is_res(input logic [5:0] s, input logic [19:0] t);
        return (cnt[s] >= 1 && mru_t[s] == t) || (cnt[s] == 2 && lru_t[s] == t);
    endfunction

    function automatic void touch(input logic [5:0] s, input logic [19:0] t);
        if (cnt[s] == 2 && lru_t[s] == t && mru_t[s] != t) begin
            lru_t[s] = mru_t[s];
            mru_t[s] = t;
        end
    endfunction

    function automatic void insert(input logic [5:0] s, input logic [19:0] t);
        if (cnt[s] == 0) begin
            mru_t[s] = t;
            cnt[s]   = 1;
        end else begin
            lru_t[s] = mru_t[s];
            mru_t[s] = t;
            cnt[s]   = 2;
        end
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 64; s++) cnt[s] = 0;
        exp_dout = '0;
    endfunction

    task automatic wait_pulse(input bit is_rd);
        int n = 0;
        while (((is_rd ? main_mem_read_req : main_mem_write_req) !== 1'b1) && n < 16) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic mem_ack(input logic [511:0] line);
        @(negedge clk);
        main_mem_data_in = line;
        main_mem_ready   = 1'b1;
        @(posedge clk); #1;
        main_mem_ready   = 1'b0;
        main_mem_data_in = {16{$urandom}};
    endtask

    task automatic do_read(input logic [31:0] a);
        logic [5:0]  s;
        logic [19:0] t;
        bit          exp_hit;
        logic [31:0] exp_w;
        int          d;
        s = a[11:6];
        t = a[31:12];
        exp_hit = is_res(s, t);
        exp_w   = mem_rd(a);
        @(negedge clk);
        phy_addr = a; read_mem = 1'b1; write_mem = 1'b0; data_from_cpu = $urandom;
        @(posedge clk); #1;
        read_mem = 1'b0; phy_addr = $urandom;
        check_eq("rd_hit_miss", {31'd0, hit_miss}, {31'd0, exp_hit});
        if (exp_hit) begin
            check_eq("rd_hit_stall", {31'd0, ready_stall}, 32'd0);
            check_eq("rd_hit_data", data_to_cpu, exp_w);
            check_eq("rd_hit_noreq", {31'd0, main_mem_read_req}, 32'd0);
            touch(s, t);
        end else begin
            check_eq("rd_miss_stall", {31'd0, ready_stall}, 32'd1);
            wait_pulse(1'b1);
            check_eq("rd_req", {31'd0, main_mem_read_req}, 32'd1);
            check_eq("rd_req_addr", main_mem_addr, {a[31:6], 6'd0});
            @(posedge clk); #1;
            check_eq("rd_req_once", {31'd0, main_mem_read_req}, 32'd0);
            d = $urandom_range(0, 3);
            repeat (d) begin
                @(posedge clk); #1;
                check_eq("rd_wait_stall", {31'd0, ready_stall}, 32'd1);
            end
            mem_ack(line_of(a));
            check_eq("rd_fill_stall", {31'd0, ready_stall}, 32'd0);
            check_eq("rd_fill_data", data_to_cpu, exp_w);
            check_eq("rd_fill_hm", {31'd0, hit_miss}, 32'd0);
            insert(s, t);
        end
        exp_dout = exp_w;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input bit both);
        logic [5:0]  s;
        logic [19:0] t;
        bit          exp_hit;
        int          d;
        s = a[11:6];
        t = a[31:12];
        exp_hit = is_res(s, t);
        @(negedge clk);
        phy_addr = a; data_from_cpu = wd; write_mem = 1'b1; read_mem = both;
        @(posedge clk); #1;
        write_mem = 1'b0; read_mem = 1'b0; phy_addr = $urandom; data_from_cpu = $urandom;
        check_eq("wr_stall", {31'd0, ready_stall}, 32'd1);
        check_eq("wr_hit_miss", {31'd0, hit_miss}, {31'd0, exp_hit});
        check_eq("wr_dout_hold", data_to_cpu, exp_dout);
        wait_pulse(1'b0);
        check_eq("wr_req", {31'd0, main_mem_write_req}, 32'd1);
        check_eq("wr_req_addr", main_mem_addr, a);
        check_eq("wr_req_data", main_mem_data_out, wd);
        check_eq("wr_no_rdreq", {31'd0, main_mem_read_req}, 32'd0);
        @(posedge clk); #1;
        check_eq("wr_req_once", {31'd0, main_mem_write_req}, 32'd0);
        d = $urandom_range(0, 3);
        repeat (d) @(posedge clk);
        #1;
        check_eq("wr_wait_stall", {31'd0, ready_stall}, 32'd1);
        mem_ack({16{$urandom}});
        check_eq("wr_done_stall", {31'd0, ready_stall}, 32'd0);
        check_eq("wr_done_dout", data_to_cpu, exp_dout);
        mem_ovr[a[31:2]] = wd;
        if (exp_hit) touch(s, t);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_dout"},  data_to_cpu, 32'd0);
        check_eq({pfx, "_hm"},    {31'd0, hit_miss}, 32'd0);
        check_eq({pfx, "_stall"}, {31'd0, ready_stall}, 32'd0);
        check_eq({pfx, "_addr"},  main_mem_addr, 32'd0);
        check_eq({pfx, "_wdata"}, main_mem_data_out, 32'd0);
        check_eq({pfx, "_reqs"},  {30'd0, main_mem_read_req, main_mem_write_req}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int          op;
        rst_n = 1'b0; phy_addr = '0; data_from_cpu = '0;
        read_mem = 1'b0; write_mem = 1'b0;
        main_mem_data_in = '0; main_mem_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        mem_ovr[30'h11] = 32'hA5A5A5A5;
        do_read(32'h0000_0044);
        do_read(32'h0000_0044);
        do_write(32'h0000_0044, 32'h1234_5678, 1'b0);
        do_read(32'h0000_0044);
        do_write(32'h0000_1080, 32'h0000_0007, 1'b0);
        do_read(32'h0000_1080);
        do_read(32'h0000_0000);
        do_read(32'h0000_1000);
        do_read(32'h0000_0000);
        do_read(32'h0000_2000);
        do_read(32'h0000_0000);
        do_read(32'h0000_1000);

        for (int i = 0; i < 250; i++) begin
            a  = {18'd0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 4'($urandom), 2'($urandom)};
            op = $urandom_range(0, 3);
            if (op < 2)       do_read(a);
            else if (op == 2) do_write(a, $urandom, 1'b0);
            else              do_write(a, $urandom, 1'b1);
        end

        // Abort a line fill mid-flight
        @(negedge clk);
        phy_addr = 32'hABCD_E7C4; read_mem = 1'b1;
        @(posedge clk); #1;
        read_mem = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        do_read(32'hABCD_E7C4);
        do_read(32'h0000_0044);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
